apb_master_mux: RTL and testbench
=================================

Name: apb_master_mux

Overview:
- Parametrised APB master and slave-select fabric for the RV32I MCU; converts the core's single-cycle `transfer`/`ready` data-bus handshake into APB3 SETUP/ACCESS cycles.
- Generalises the fixed 14-slot master to NUM_SLV slots decoded from an address window.
- Adds PSLVERR propagation, unmapped-address error response and a PREADY timeout.
- Sits between RV32I_Core and all APB peripherals (RAM, timers, GPIO, FND, UART, ...).

Parameters:
- NUM_SLV, 16, number of APB slave slots (1..32).
- DATA_W, 32, PWDATA/PRDATA width.
- BASE_ADDR, 32'h1000_0000, start of the peripheral window.
- SLOT_LOG2, 12, log2 of bytes per slot (4 KB).
- TIMEOUT_CYC, 255, maximum ACCESS cycles before forced error completion (only with APB_TIMEOUT_EN).

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous, active-low reset.
- transfer  in  1  request pulse from core; sampled only in IDLE.
- write  in  1  1 = write, 0 = read.
- addr  in  32  byte address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data, valid while ready = 1.
- ready  out  1  one-cycle completion pulse.
- error  out  1  completion carries an error; valid with ready.
- PADDR  out  32  APB address.
- PWDATA  out  DATA_W  APB write data.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- PSEL  out  NUM_SLV  one-hot slave select.
- PRDATA  in  NUM_SLV*DATA_W  slot i occupies bits [i*DATA_W +: DATA_W].
- PREADY  in  NUM_SLV  per-slot ready.
- PSLVERR  in  NUM_SLV  per-slot error.

Behaviour:
- Reset (PRESET = 0, async): state IDLE; PADDR = 0, PWDATA = 0, PWRITE = 0, PENABLE = 0, PSEL = 0, rdata = 0, ready = 0, error = 0, timeout counter = 0.
- Decode is combinational on the latched address:
  - hit = (addr >= BASE_ADDR) and (addr < BASE_ADDR + NUM_SLV << SLOT_LOG2).
  - idx = (addr - BASE_ADDR) >> SLOT_LOG2.
  - Unmapped (miss) asserts no PSEL bit.
- FSM:
  - IDLE: if transfer = 1, latch addr/wdata/write into PADDR/PWDATA/PWRITE, latch hit/idx, go to SETUP. transfer = 0 stays in IDLE.
  - SETUP (1 cycle): PSEL[idx] = 1 on a hit, PENABLE = 0; go to ACCESS.
  - ACCESS: PSEL held, PENABLE = 1. Completion when any of:
    - (a) hit and PREADY[idx] = 1;
    - (b) miss (completes in the first ACCESS cycle);
    - (c) timeout.
  - On completion: next cycle is IDLE with PSEL = 0, PENABLE = 0, and a one-cycle `ready` pulse.
- Completion outputs (registered):
  - rdata = PRDATA slot idx on a normal read.
  - rdata = 0 on writes, misses and timeouts.
  - error = PSLVERR[idx] for (a); error = 1 for (b) and (c).
- Latency:
  - transfer in cycle N, zero-wait slave → ready in cycle N+3.
  - Each wait state adds 1 cycle.
- transfer while not IDLE is ignored; the core holds the request until ready.
- transfer in the same cycle ready is high is accepted (FSM is already IDLE), giving back-to-back accesses.
- PADDR/PWDATA/PWRITE remain stable from SETUP through the last ACCESS cycle and hold their value in IDLE.
- PREADY/PSLVERR of non-selected slots are ignored.
- Reset mid-transfer aborts immediately: no ready pulse, all outputs at reset values.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - 8..16-bit counter clears on SETUP and increments every ACCESS cycle without PREADY.
  - When the counter reaches TIMEOUT_CYC, the access completes with error = 1, rdata = 0.
- Undefined: no counter; ACCESS waits indefinitely for PREADY; TIMEOUT_CYC is unused.

Decomposition:
- apb_pkg holds:
  - `apb_state_e` enum {IDLE, SETUP, ACCESS};
  - default BASE_ADDR / SLOT_LOG2 constants;
  - named slot indices (SLOT_RAM = 0, SLOT_TIMER = 1, SLOT_GPIOA = 2, ..., SLOT_BUZZER = 13).
- One sub-module, apb_addr_decoder: combinational addr → {hit, idx, one-hot sel}, parametrised on NUM_SLV/BASE_ADDR/SLOT_LOG2.

Test Plan:
- Write 0x1000_2004 ← 0xDEAD_BEEF, slot 2 PREADY tied 1 → PSEL = 16'h0004, PENABLE high 1 cycle, ready 3 cycles after transfer, error = 0.
- Read 0x1000_5000, slot 5 inserts 2 wait states with PRDATA = 0x0000_00A5 → ready at N+5, rdata = 0x0000_00A5, error = 0.
- Read 0x2000_0000 (unmapped) → PSEL stays 0, ready at N+3, rdata = 0, error = 1.
- Slot 7 read with PREADY = 1 and PSLVERR = 1 → ready with error = 1; next transfer asserted in the ready cycle starts SETUP on the following cycle.
- APB_TIMEOUT_EN, TIMEOUT_CYC = 8, slot 3 PREADY stuck 0 → ready after 8 ACCESS cycles, error = 1, rdata = 0, PSEL then 0.
- PRESET pulsed low during ACCESS of slot 1 → PSEL, PENABLE and ready go 0 asynchronously; FSM in IDLE after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master/slave-select fabric.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  localparam logic [31:0]  DEF_BASE_ADDR = 32'h1000_0000;
  localparam int unsigned  DEF_SLOT_LOG2 = 12;

  typedef enum int unsigned {
    SLOT_RAM    = 0,
    SLOT_TIMER  = 1,
    SLOT_GPIOA  = 2,
    SLOT_GPIOB  = 3,
    SLOT_GPIOC  = 4,
    SLOT_GPIOD  = 5,
    SLOT_FND    = 6,
    SLOT_UART   = 7,
    SLOT_TIMER1 = 8,
    SLOT_I2C    = 9,
    SLOT_SPI    = 10,
    SLOT_ADC    = 11,
    SLOT_PWM    = 12,
    SLOT_BUZZER = 13
  } apb_slot_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address-window decoder: byte address -> {hit, slot index, one-hot select}.
module apb_addr_decoder import apb_pkg::*; #(
  parameter int unsigned NUM_SLV   = 16,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned SLOT_LOG2 = DEF_SLOT_LOG2,
  parameter int unsigned IDX_W     = 4
) (
  input  logic [31:0]        addr,
  output logic               hit,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_SLV-1:0] sel
);

  // 33-bit end bound so a window touching the top of the address space cannot wrap
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(NUM_SLV) << SLOT_LOG2);

  logic [31:0] offset;

  always_comb begin
    offset = addr - BASE_ADDR;
    hit    = (addr >= BASE_ADDR) && ({1'b0, addr} < END_ADDR);
    idx    = IDX_W'(offset >> SLOT_LOG2);
    sel    = hit ? (NUM_SLV'(1) << idx) : '0;
  end

endmodule

// File: rtl/apb_master_mux.sv
// APB3 master + slave-select fabric: core transfer/ready handshake to SETUP/ACCESS cycles.
// Optional PREADY timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_mux import apb_pkg::*; #(
  parameter int unsigned NUM_SLV     = 16,
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned SLOT_LOG2   = DEF_SLOT_LOG2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      transfer,
  input  logic                      write,
  input  logic [31:0]               addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ready,
  output logic                      error,
  output logic [31:0]               PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  if (NUM_SLV < 1 || NUM_SLV > 32 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
    $error("apb_master_mux: unsupported parameter set");
  end

  apb_state_e               state;
  logic                     hit_d, hit_q;
  logic [IDX_W-1:0]         idx_d, idx_q;
  logic [NUM_SLV-1:0]       sel_d;
  logic [DATA_W-1:0]        prdata_s, done_rdata;
  logic                     pready_s, pslverr_s, done, done_err;

`ifdef APB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_cnt;
`endif

  apb_addr_decoder #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR),
    .SLOT_LOG2 (SLOT_LOG2),
    .IDX_W     (IDX_W)
  ) u_dec (
    .addr (addr),
    .hit  (hit_d),
    .idx  (idx_d),
    .sel  (sel_d)
  );

  // Only the latched slot's response is observed; other slots are ignored.
  always_comb begin
    prdata_s  = '0;
    pready_s  = 1'b0;
    pslverr_s = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        prdata_s  = PRDATA[i*DATA_W +: DATA_W];
        pready_s  = PREADY[i];
        pslverr_s = PSLVERR[i];
      end
    end
  end

  always_comb begin
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    if (state == ACCESS) begin
      if (!hit_q) begin
        done     = 1'b1;
        done_err = 1'b1;
      end else if (pready_s) begin
        done     = 1'b1;
        done_err = pslverr_s;
        if (!PWRITE) done_rdata = prdata_s;
      end
`ifdef APB_TIMEOUT_EN
      else if (tmo_cnt == TMO_LAST) begin
        done     = 1'b1;
        done_err = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state   <= IDLE;
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
      PENABLE <= 1'b0;
      PSEL    <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      error   <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            PADDR  <= addr;
            PWDATA <= wdata;
            PWRITE <= write;
            hit_q  <= hit_d;
            idx_q  <= idx_d;
            PSEL   <= sel_d;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (done) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            error   <= done_err;
            rdata   <= done_rdata;
            state   <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_mux.sv
// Self-checking bench for apb_master_mux: directed table, corner sequences, randomized model check.
module tb_apb_master_mux;

  localparam int unsigned NS   = 16;
  localparam int unsigned DW   = 32;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int unsigned SLOT_BYTES = 4096;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic            transfer, write;
  logic [31:0]     addr;
  logic [DW-1:0]   wdata, rdata;
  logic            ready, error;
  logic [31:0]     PADDR;
  logic [DW-1:0]   PWDATA;
  logic            PWRITE, PENABLE;
  logic [NS-1:0]   PSEL;
  logic [NS*DW-1:0] PRDATA;
  logic [NS-1:0]   PREADY, PSLVERR;

  int unsigned checks = 0;
  int unsigned errors = 0;

  apb_master_mux #(
    .NUM_SLV     (NS),
    .DATA_W      (DW),
    .BASE_ADDR   (BASE),
    .SLOT_LOG2   (12),
    .TIMEOUT_CYC (8)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .error    (error),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Slave side: selected slot answers per cfg_*; every other slot drives random noise.
  int unsigned      cfg_wait;
  logic             cfg_err;
  logic [31:0]      cfg_rdata;
  bit               cfg_stuck;
  int unsigned      acc_cnt;
  logic [NS-1:0]    noise_rdy, noise_err;
  logic [NS*DW-1:0] noise_data;

  always @(posedge PCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

  always @(negedge PCLK) begin
    noise_rdy <= NS'($urandom());
    noise_err <= NS'($urandom());
    for (int i = 0; i < NS; i++) noise_data[i*DW +: DW] <= $urandom();
  end

  always_comb begin
    PREADY  = noise_rdy;
    PSLVERR = noise_err;
    PRDATA  = noise_data;
    for (int i = 0; i < NS; i++) begin
      if (PSEL[i]) begin
        PREADY[i]            = PENABLE && !cfg_stuck && (acc_cnt >= cfg_wait);
        PSLVERR[i]           = cfg_err;
        PRDATA[i*DW +: DW]   = cfg_rdata;
      end
    end
  end

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int unsigned ws;
    logic        se;
    logic [31:0] sd;
    bit          stuck;
    int unsigned e_lat;
    logic [15:0] e_psel;
    logic [31:0] e_rdata;
    bit          chk_rd;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input int unsigned ws, input logic se, input logic [31:0] sd,
                              input bit stuck, input int unsigned lat, input logic [15:0] psel,
                              input logic [31:0] rd, input bit chk_rd, input logic err);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.ws = ws; v.se = se; v.sd = sd; v.stuck = stuck;
    v.e_lat = lat; v.e_psel = psel; v.e_rdata = rd; v.chk_rd = chk_rd; v.e_err = err;
    return v;
  endfunction

  // Reference model: window arithmetic on the byte address, latency = 3 + wait states.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    longint unsigned a64 = longint'(v.a);
    longint unsigned lo  = longint'(BASE);
    longint unsigned hi  = lo + NS * SLOT_BYTES;
    bit hit = (a64 >= lo) && (a64 < hi);
    int unsigned slot = hit ? int'((a64 - lo) / SLOT_BYTES) : 0;
    r.e_lat   = hit ? 3 + v.ws : 3;
    r.e_psel  = hit ? 16'(32'd1 << slot) : 16'h0;
    r.e_err   = hit ? v.se : 1'b1;
    r.e_rdata = (hit && !v.w) ? v.sd : 32'h0;
    r.chk_rd  = !(hit && v.se);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned lat = 0, en_cnt = 0;
    logic [15:0] psel_or = '0, psel_at = '0;
    logic [31:0] rd = '0;
    logic        er = 1'b0, en_at = 1'b0;
    bit          stable = 1'b1, seen = 1'b0;
    cfg_wait = v.ws; cfg_err = v.se; cfg_rdata = v.sd; cfg_stuck = v.stuck;
    @(negedge PCLK);
    transfer = 1'b1; write = v.w; addr = v.a; wdata = v.d;
    for (int k = 1; k <= 64; k++) begin
      @(negedge PCLK);
      transfer = 1'b0;
      if (PADDR !== v.a || PWDATA !== v.d || PWRITE !== v.w) stable = 1'b0;
      if (PENABLE) en_cnt++;
      psel_or |= PSEL;
      if (ready) begin
        lat = k; seen = 1'b1; rd = rdata; er = error; psel_at = PSEL; en_at = PENABLE;
        break;
      end
    end
    if (!seen) $display("FAIL %s_no_ready: got none expected ready within 64 cycles", tag);
    chk({tag, "_latency"}, lat, v.e_lat);
    chk({tag, "_psel"}, psel_or, v.e_psel);
    chk({tag, "_penable_cycles"}, en_cnt, v.e_lat - 2);
    chk({tag, "_error"}, er, v.e_err);
    if (v.chk_rd) chk({tag, "_rdata"}, rd, v.e_rdata);
    chk({tag, "_psel_at_ready"}, psel_at, 0);
    chk({tag, "_penable_at_ready"}, en_at, 0);
    chk({tag, "_addr_stable"}, stable, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET = 1'b0; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    cfg_wait = 0; cfg_err = 1'b0; cfg_rdata = '0; cfg_stuck = 1'b0;

    vecs.push_back(mk(1, 32'h1000_2004, 32'hDEAD_BEEF, 0, 0, 32'h1111_1111, 0, 3, 16'h0004, 32'h0, 1, 0));
    vecs.push_back(mk(0, 32'h1000_5000, 32'h0,         2, 0, 32'h0000_00A5, 0, 5, 16'h0020, 32'hA5, 1, 0));
    vecs.push_back(mk(0, 32'h2000_0000, 32'h0,         0, 0, 32'h5555_5555, 0, 3, 16'h0000, 32'h0, 1, 1));
    vecs.push_back(mk(0, 32'h1000_7010, 32'h0,         0, 1, 32'h7777_7777, 0, 3, 16'h0080, 32'h0, 0, 1));
    vecs.push_back(mk(0, 32'h1000_FFFC, 32'h0,         1, 0, 32'h0000_1234, 0, 4, 16'h8000, 32'h1234, 1, 0));
    vecs.push_back(mk(0, 32'h1001_0000, 32'h0,         0, 0, 32'h9999_9999, 0, 3, 16'h0000, 32'h0, 1, 1));
    vecs.push_back(mk(0, 32'h0FFF_FFFC, 32'h0,         0, 0, 32'h9999_9999, 0, 3, 16'h0000, 32'h0, 1, 1));
    vecs.push_back(mk(1, 32'h1000_0000, 32'hCAFE_F00D, 3, 1, 32'h1234_5678, 0, 6, 16'h0001, 32'h0, 1, 1));
`ifdef APB_TIMEOUT_EN
    vecs.push_back(mk(0, 32'h1000_3000, 32'h0,         0, 0, 32'hABCD_0123, 1, 10, 16'h0008, 32'h0, 1, 1));
`endif

    repeat (3) @(negedge PCLK);
    chk("reset_psel", PSEL, 0);
    chk("reset_penable", PENABLE, 0);
    chk("reset_ready", ready, 0);
    chk("reset_error", error, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_paddr", PADDR, 0);
    chk("reset_pwdata", PWDATA, 0);
    chk("reset_pwrite", PWRITE, 0);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("idle_no_transfer_psel", PSEL, 0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: new transfer raised during the ready cycle enters SETUP next cycle.
    cfg_wait = 0; cfg_err = 1'b1; cfg_rdata = 32'h0; cfg_stuck = 1'b0;
    @(negedge PCLK); transfer = 1'b1; write = 1'b0; addr = 32'h1000_7000;
    @(negedge PCLK); transfer = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("b2b_first_ready", ready, 1);
    chk("b2b_first_error", error, 1);
    transfer = 1'b1; addr = 32'h1000_2000;
    @(negedge PCLK);
    transfer = 1'b0; cfg_err = 1'b0; cfg_rdata = 32'h0000_0055;
    chk("b2b_setup_psel", PSEL, 16'h0004);
    chk("b2b_setup_penable", PENABLE, 0);
    chk("b2b_setup_ready", ready, 0);
    @(negedge PCLK);
    chk("b2b_access_penable", PENABLE, 1);
    @(negedge PCLK);
    chk("b2b_second_ready", ready, 1);
    chk("b2b_second_rdata", rdata, 32'h0000_0055);
    chk("b2b_second_error", error, 0);

    // Asynchronous reset during ACCESS of slot 1.
    cfg_stuck = 1'b1;
    @(negedge PCLK); transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000;
    @(negedge PCLK); transfer = 1'b0;
    @(negedge PCLK);
    chk("rst_mid_pre_psel", PSEL, 16'h0002);
    chk("rst_mid_pre_penable", PENABLE, 1);
    #2 PRESET = 1'b0;
    #1;
    chk("rst_mid_psel", PSEL, 0);
    chk("rst_mid_penable", PENABLE, 0);
    chk("rst_mid_ready", ready, 0);
    chk("rst_mid_paddr", PADDR, 0);
    @(negedge PCLK); PRESET = 1'b1; cfg_stuck = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_after_psel", PSEL, 0);
    chk("rst_after_ready", ready, 0);
    run_vec(mk(0, 32'h1000_1008, 32'h0, 1, 0, 32'h0BAD_F00D, 0, 4, 16'h0002, 32'h0BAD_F00D, 1, 0), "rst_recover");

    // Randomized transactions against the window-arithmetic model.
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      int unsigned mode = $urandom_range(0, 9);
      v.w  = 1'($urandom());
      v.d  = $urandom();
      v.ws = $urandom_range(0, 3);
      v.se = ($urandom_range(0, 3) == 0);
      v.sd = $urandom();
      v.stuck = 1'b0;
      if (mode < 7)       v.a = (BASE + $urandom_range(0, NS * SLOT_BYTES - 1)) & 32'hFFFF_FFFC;
      else if (mode == 7) v.a = BASE + NS * SLOT_BYTES + ($urandom_range(0, 255) << 2);
      else if (mode == 8) v.a = BASE - 4 - ($urandom_range(0, 255) << 2);
      else                v.a = $urandom() & 32'hFFFF_FFFC;
      run_vec(model(v), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
